// File: rtl/robo_seguidor_param.sv
// Wall-following controller with debounced sensors, rotation timeout and back-up recovery.
// Sensor to state latency: a raw change stable before edge k moves the state at edge k+2+DEBOUNCE_CYCLES.
// No backpressure: Moore outputs decoded from the state register; TRAVADO is left only by reset.

// Per-sensor input conditioning: 2-flop synchroniser followed by a stability filter.
module robo_seguidor_param_debounce #(
  parameter int CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive cycles the synchronised value disagrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser and filter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

module robo_seguidor_param #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int ROT_TIMEOUT     = 16,
  parameter int BACK_CYCLES     = 4,
  parameter int MAX_RETRIES     = 3,
  parameter int SIDE            = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       head,
  input  logic       side,
  output logic       avancar,
  output logic       girar,
  output logic       girar_dir,
  output logic       recuar,
  output logic       travado,
  output logic [2:0] estado_out
);

  localparam logic [2:0] PARADO       = 3'b000;
  localparam logic [2:0] PROCURANDO   = 3'b001;
  localparam logic [2:0] ROTACIONANDO = 3'b010;
  localparam logic [2:0] ACOMPANHANDO = 3'b011;
  localparam logic [2:0] RECUANDO     = 3'b100;
  localparam logic [2:0] TRAVADO      = 3'b101;

  localparam int RW = $clog2(ROT_TIMEOUT) + 1;
  localparam int BW = $clog2(BACK_CYCLES) + 1;
  localparam int TW = $clog2(MAX_RETRIES) + 1;

  localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_TIMEOUT - 1);
  localparam logic [RW-1:0] ROT_MAX   = RW'(ROT_TIMEOUT);
  localparam logic [BW-1:0] BACK_LAST = BW'(BACK_CYCLES - 1);
  localparam logic [BW-1:0] BACK_MAX  = BW'(BACK_CYCLES);
  localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRIES);

  // Rotation always turns away from the followed wall.
  localparam logic SIDE_BIT = (SIDE != 0);

  logic          head_f;
  logic          side_f;
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [RW-1:0] rot_cnt_q;
  logic [RW-1:0] rot_cnt_d;
  logic [BW-1:0] back_cnt_q;
  logic [BW-1:0] back_cnt_d;
  logic [TW-1:0] retries_q;
  logic [TW-1:0] retries_d;
  logic          enter_rot;
  logic          enter_rec;

  robo_seguidor_param_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_head (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (head),
    .filt_o (head_f)
  );

  robo_seguidor_param_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_side (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (side),
    .filt_o (side_f)
  );

  // Next-state rules: stop request beats everything except the latched stuck state.
  always_comb begin
    state_d = state_q;
    if (!enable && state_q != TRAVADO) begin
      state_d = PARADO;
    end else begin
      case (state_q)
        PARADO: begin
          state_d = PROCURANDO;
        end
        PROCURANDO: begin
          if (head_f) begin
            state_d = ROTACIONANDO;
          end else if (side_f) begin
            state_d = ACOMPANHANDO;
          end
        end
        ROTACIONANDO: begin
          // Finding the wall again takes precedence over giving up on the rotation.
          if (!head_f && side_f) begin
            state_d = ACOMPANHANDO;
          end else if (rot_cnt_q == ROT_LAST) begin
            state_d = RECUANDO;
          end
        end
        ACOMPANHANDO: begin
          if (!side_f) begin
            state_d = PROCURANDO;
          end else if (head_f) begin
            state_d = ROTACIONANDO;
          end
        end
        RECUANDO: begin
          // Sensors are deliberately ignored while backing up.
          if (back_cnt_q == BACK_LAST) begin
            state_d = (retries_q == RETRY_MAX) ? TRAVADO : ROTACIONANDO;
          end
        end
        TRAVADO: begin
          state_d = TRAVADO;
        end
        default: begin
          state_d = PARADO;
        end
      endcase
    end
  end

  assign enter_rot = (state_d == ROTACIONANDO) && (state_q != ROTACIONANDO);
  assign enter_rec = (state_d == RECUANDO) && (state_q != RECUANDO);

  // Counter updates: clear on state entry, saturate instead of wrapping.
  always_comb begin
    rot_cnt_d  = rot_cnt_q;
    back_cnt_d = back_cnt_q;
    retries_d  = retries_q;

    if (enter_rot) begin
      rot_cnt_d = '0;
    end else if (state_q == ROTACIONANDO && rot_cnt_q != ROT_MAX) begin
      rot_cnt_d = rot_cnt_q + RW'(1);
    end

    if (enter_rec) begin
      back_cnt_d = '0;
    end else if (state_q == RECUANDO && back_cnt_q != BACK_MAX) begin
      back_cnt_d = back_cnt_q + BW'(1);
    end

    // Reaching the wall or being stopped forgives earlier back-ups.
    if (state_d == ACOMPANHANDO || state_d == PARADO) begin
      retries_d = '0;
    end else if (enter_rec && retries_q != RETRY_MAX) begin
      retries_d = retries_q + TW'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= PARADO;
      rot_cnt_q  <= '0;
      back_cnt_q <= '0;
      retries_q  <= '0;
    end else begin
      state_q    <= state_d;
      rot_cnt_q  <= rot_cnt_d;
      back_cnt_q <= back_cnt_d;
      retries_q  <= retries_d;
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    avancar = 1'b0;
    girar   = 1'b0;
    recuar  = 1'b0;
    travado = 1'b0;
    case (state_q)
      PROCURANDO:   avancar = 1'b1;
      ROTACIONANDO: girar   = 1'b1;
      ACOMPANHANDO: avancar = 1'b1;
      RECUANDO:     recuar  = 1'b1;
      TRAVADO:      travado = 1'b1;
      default: begin
        avancar = 1'b0;
      end
    endcase
  end

  assign girar_dir  = ~SIDE_BIT;
  assign estado_out = state_q;

endmodule

// File: tb/tb_robo_seguidor_param.sv
// Bench for robo_seguidor_param: directed plan steps followed by random sensor traffic,
// all outputs compared each cycle against a behavioural model of the controller.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_robo_seguidor_param;

  localparam int D  = 2;
  localparam int RT = 8;
  localparam int BC = 4;
  localparam int MR = 2;

  localparam logic [2:0] S_PAR = 3'd0;
  localparam logic [2:0] S_PRO = 3'd1;
  localparam logic [2:0] S_ROT = 3'd2;
  localparam logic [2:0] S_ACO = 3'd3;
  localparam logic [2:0] S_REC = 3'd4;
  localparam logic [2:0] S_TRV = 3'd5;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       head   = 1'b0;
  logic       side   = 1'b0;
  logic       avancar;
  logic       girar;
  logic       girar_dir;
  logic       recuar;
  logic       travado;
  logic [2:0] estado_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode, time spent in the current mode, back-ups since last success,
  // and for each sensor a delay line plus a count of consecutive disagreeing samples.
  logic [2:0] m_state;
  int         m_time;
  int         m_backups;
  logic       m_h1, m_h2, m_hf, m_s1, m_s2, m_sf;
  int         m_hrun, m_srun;

  robo_seguidor_param #(
    .DEBOUNCE_CYCLES (D),
    .ROT_TIMEOUT     (RT),
    .BACK_CYCLES     (BC),
    .MAX_RETRIES     (MR),
    .SIDE            (0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .head       (head),
    .side       (side),
    .avancar    (avancar),
    .girar      (girar),
    .girar_dir  (girar_dir),
    .recuar     (recuar),
    .travado    (travado),
    .estado_out (estado_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_step();
    logic [2:0] nxt;
    logic       h, s;
    if (reset) begin
      m_state   = S_PAR;
      m_time    = 0;
      m_backups = 0;
      m_h1 = 1'b0; m_h2 = 1'b0; m_hf = 1'b0; m_hrun = 0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_sf = 1'b0; m_srun = 0;
      return;
    end
    h   = m_hf;
    s   = m_sf;
    nxt = m_state;
    if (m_state == S_TRV)   nxt = S_TRV;
    else if (!enable)       nxt = S_PAR;
    else begin
      case (m_state)
        S_PAR: nxt = S_PRO;
        S_PRO: if (h) nxt = S_ROT; else if (s) nxt = S_ACO;
        S_ROT: if (!h && s) nxt = S_ACO; else if (m_time == RT - 1) nxt = S_REC;
        S_ACO: if (!s) nxt = S_PRO; else if (h) nxt = S_ROT;
        S_REC: if (m_time == BC - 1) nxt = (m_backups == MR) ? S_TRV : S_ROT;
        default: nxt = S_PAR;
      endcase
    end
    if (nxt == S_REC && m_state != S_REC && m_backups < MR) m_backups++;
    if (nxt == S_ACO || nxt == S_PAR) m_backups = 0;
    m_time  = (nxt == m_state) ? m_time + 1 : 0;
    m_state = nxt;
    // A filtered value follows the synchronised one after D consecutive disagreeing samples.
    if (m_h2 != m_hf) begin
      m_hrun++;
      if (m_hrun == D) begin m_hf = m_h2; m_hrun = 0; end
    end else m_hrun = 0;
    if (m_s2 != m_sf) begin
      m_srun++;
      if (m_srun == D) begin m_sf = m_s2; m_srun = 0; end
    end else m_srun = 0;
    m_h2 = m_h1; m_h1 = head;
    m_s2 = m_s1; m_s1 = side;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("estado_out", estado_out, m_state);
    chk("avancar", {2'b00, avancar}, {2'b00, (m_state == S_PRO || m_state == S_ACO)});
    chk("girar",   {2'b00, girar},   {2'b00, (m_state == S_ROT)});
    chk("recuar",  {2'b00, recuar},  {2'b00, (m_state == S_REC)});
    chk("travado", {2'b00, travado}, {2'b00, (m_state == S_TRV)});
    chk("girar_dir", {2'b00, girar_dir}, 3'd1);
  endtask

  task automatic wait_state(input logic [2:0] target, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      step();
      if (m_state == target) break;
    end
    n_checks++;
    assert (m_state == target) n_pass++;
    else $error("FAIL %s: model state %0d never reached %0d", tag, m_state, target);
  endtask

  initial begin
    // 1: reset, then enable
    reset = 1'b1; enable = 1'b0; head = 1'b0; side = 1'b0;
    step(); step();
    chk("t1_reset_state", estado_out, S_PAR);
    chk("t1_reset_girar_dir", {2'b00, girar_dir}, 3'd1);
    reset = 1'b0;
    step();
    chk("t1_disabled_idle", estado_out, S_PAR);
    enable = 1'b1;
    step();
    chk("t1_procurando", estado_out, S_PRO);
    chk("t1_avancar", {2'b00, avancar}, 3'd1);

    // 2: one-cycle glitch ignored, held head rotates after k+4
    head = 1'b1; step(); head = 1'b0;
    repeat (6) step();
    chk("t2_glitch_ignored", estado_out, S_PRO);
    head = 1'b1;
    repeat (4) step();
    chk("t2_not_yet", estado_out, S_PRO);
    step();
    chk("t2_rotacionando", estado_out, S_ROT);
    chk("t2_girar", {2'b00, girar}, 3'd1);

    // 3: escape to wall, then lose wall
    head = 1'b0; side = 1'b1;
    repeat (4) step();
    chk("t3_still_rot", estado_out, S_ROT);
    step();
    chk("t3_acompanhando", estado_out, S_ACO);
    side = 1'b0;
    repeat (4) step();
    chk("t3_hold_aco", estado_out, S_ACO);
    step();
    chk("t3_back_procurando", estado_out, S_PRO);

    // 4: timeouts, two back-ups, stuck
    head = 1'b1; side = 1'b0;
    wait_state(S_ROT, 10, "t4_rot_entry");
    repeat (7) step();
    chk("t4_rot_hold", estado_out, S_ROT);
    step();
    chk("t4_rec1", estado_out, S_REC);
    chk("t4_recuar", {2'b00, recuar}, 3'd1);
    repeat (3) step();
    chk("t4_rec1_hold", estado_out, S_REC);
    step();
    chk("t4_rot_again", estado_out, S_ROT);
    repeat (8) step();
    chk("t4_rec2", estado_out, S_REC);
    repeat (4) step();
    chk("t4_travado", estado_out, S_TRV);
    chk("t4_travado_flag", {2'b00, travado}, 3'd1);
    enable = 1'b0; step(); step(); enable = 1'b1; step();
    chk("t4_stuck_ignores_enable", estado_out, S_TRV);
    reset = 1'b1; step();
    chk("t4_reset_exit", estado_out, S_PAR);

    // 5: escape on the same cycle as the timeout
    reset = 1'b0; head = 1'b0; side = 1'b0; enable = 1'b1;
    step();
    head = 1'b1;
    wait_state(S_ROT, 10, "t5_rot_entry");
    repeat (3) step();
    head = 1'b0; side = 1'b1;
    repeat (4) step();
    chk("t5_rot_last_cycle", estado_out, S_ROT);
    step();
    chk("t5_escape_wins", estado_out, S_ACO);

    // 6: stop mid back-up, retries forgotten
    reset = 1'b1; step();
    reset = 1'b0; head = 1'b0; side = 1'b0; enable = 1'b1;
    step();
    head = 1'b1;
    wait_state(S_REC, 30, "t6_rec_entry");
    step(); step();
    enable = 1'b0;
    step();
    chk("t6_parado", estado_out, S_PAR);
    chk("t6_motion_off", {avancar, girar, recuar}, 3'd0);
    enable = 1'b1;
    step();
    chk("t6_reenable", estado_out, S_PRO);
    wait_state(S_REC, 30, "t6_rec_again");
    repeat (4) step();
    chk("t6_retries_cleared", estado_out, S_ROT);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 99) < 2);
      enable = ($urandom_range(0, 99) < 94);
      if ($urandom_range(0, 99) < 15) head = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 15) side = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
